// File: rtl/tc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tc_pkg
//  Description : Shared definitions for the timer_counter block: FSM state
//                encoding, register offsets, CTRL bit positions, MODE codes.
//  Revision    : 1.0  initial release
// ============================================================================
package tc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } tc_state_e;

    // Register select values (addr[3:2])
    localparam logic [1:0] c_reg_ctrl   = 2'd0;
    localparam logic [1:0] c_reg_preset = 2'd1;
    localparam logic [1:0] c_reg_count  = 2'd2;
    localparam logic [1:0] c_reg_presc  = 2'd3;

    // CTRL field positions
    localparam int c_ctrl_en_bit   = 0;
    localparam int c_ctrl_mode_lsb = 1;
    localparam int c_ctrl_mode_msb = 2;
    localparam int c_ctrl_im_bit   = 3;
    localparam int c_ctrl_width    = 4;

    // MODE codes; 10/11 fall back to one-shot behaviour
    localparam logic [1:0] c_mode_oneshot = 2'b00;
    localparam logic [1:0] c_mode_reload  = 2'b01;

endpackage : tc_pkg
`default_nettype wire

// File: rtl/tc_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tc_prescaler
//  Description : Prescale counter for timer_counter. Counts CNT cycles and
//                flags the cycle on which the count equals the programmed
//                prescale value; the counter then restarts from zero.
//  Revision    : 1.0  initial release
//  Ports       : clk      - system clock, rising edge
//                reset    - asynchronous active-low reset
//                clear_i  - restart the count (timer LOAD state)
//                run_i    - advance the count (timer counting and enabled)
//                presc_i  - prescale compare value
//                tick_o   - count equals presc_i this cycle
// ============================================================================
module tc_prescaler #(
    parameter int PRESC_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear_i,
    input  logic                   run_i,
    input  logic [PRESC_WIDTH-1:0] presc_i,
    output logic                   tick_o
);

    logic [PRESC_WIDTH-1:0] cnt_q;
    logic [PRESC_WIDTH-1:0] cnt_d;

    assign tick_o = (cnt_q == presc_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : tc_prescaler
`default_nettype wire

// File: rtl/timer_counter.sv
`default_nettype none
// ============================================================================
//  Module      : timer_counter
//  Description : Memory-mapped 32-bit down-counting timer with maskable,
//                level interrupt. One-shot and auto-reload modes.
//  Revision    : 1.0  initial release
//  Config      : define TC_PRESCALE_EN to add the PRESC register (offset 3)
//                and the tc_prescaler sub-module.
//  Ports       : clk    - system clock, rising edge
//                reset  - asynchronous active-low reset
//                addr   - bus byte address, addr[3:2] selects the register
//                we     - word write strobe (already address/byte qualified)
//                wdata  - write data
//                rdata  - combinational read data of the selected register
//                irq    - interrupt request (flag AND CTRL.IM)
//  Registers   : 0 CTRL {IM, MODE[1:0], EN}, 1 PRESET, 2 COUNT (RO),
//                3 PRESC (with TC_PRESCALE_EN) or reserved
// ============================================================================
module timer_counter
    import tc_pkg::*;
#(
    parameter int PRESC_WIDTH      = 8,
    parameter int BASE_OFFSET_BITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    tc_state_e               state_q, state_d;
    logic [c_ctrl_width-1:0] ctrl_q,  ctrl_d;
    logic [31:0]             preset_q, preset_d;
    logic [31:0]             count_q,  count_d;
    logic                    flag_q,   flag_d;

    logic [1:0] w_sel;
    logic [1:0] w_mode;
    logic       w_en;
    logic       w_auto_reload;
    logic       w_ctrl_wr;
    logic       w_tick;
    logic       w_unused_addr;

    assign w_sel         = addr[BASE_OFFSET_BITS-1 -: 2];
    assign w_unused_addr = &{1'b0, addr[31:BASE_OFFSET_BITS], addr[1:0]};
    assign w_mode        = ctrl_q[c_ctrl_mode_msb:c_ctrl_mode_lsb];
    assign w_en          = ctrl_q[c_ctrl_en_bit];
    assign w_auto_reload = (w_mode == c_mode_reload);
    assign w_ctrl_wr     = we && (w_sel == c_reg_ctrl);

`ifdef TC_PRESCALE_EN
    logic [PRESC_WIDTH-1:0] presc_q, presc_d;

    always_comb begin
        presc_d = presc_q;
        if (we && (w_sel == c_reg_presc)) begin
            presc_d = wdata[PRESC_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    tc_prescaler #(
        .PRESC_WIDTH (PRESC_WIDTH)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .clear_i (state_q == ST_LOAD),
        .run_i   ((state_q == ST_CNT) && w_en),
        .presc_i (presc_q),
        .tick_o  (w_tick)
    );
`else
    // Without the prescaler every CNT cycle is a counting cycle.
    assign w_tick = 1'b1;
    localparam int c_unused_presc_width = PRESC_WIDTH;
`endif

    // Next state. Software writes are decoded first so that the FSM's own
    // EN clear in INT can yield to a simultaneous CTRL write, while the
    // flag set on entry to INT still takes priority over the write clear.
    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;

        if (w_ctrl_wr) begin
            ctrl_d = wdata[c_ctrl_width-1:0];
            flag_d = 1'b0;
        end
        if (we && (w_sel == c_reg_preset)) begin
            preset_d = wdata;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_en) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!w_en) begin
                    state_d = ST_IDLE;
                end else if (w_tick) begin
                    // Zero is detected before decrementing, so COUNT never wraps.
                    if (count_q == 32'd0) begin
                        state_d = ST_INT;
                        flag_d  = 1'b1;
                    end else begin
                        count_d = count_q - 32'd1;
                    end
                end
            end
            ST_INT: begin
                if (w_auto_reload) begin
                    state_d = ST_LOAD;
                    flag_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                    if (!w_ctrl_wr) begin
                        ctrl_d[c_ctrl_en_bit] = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (w_sel)
            c_reg_ctrl:   rdata = {{(32-c_ctrl_width){1'b0}}, ctrl_q};
            c_reg_preset: rdata = preset_q;
            c_reg_count:  rdata = count_q;
`ifdef TC_PRESCALE_EN
            c_reg_presc:  rdata = 32'(presc_q);
`endif
            default:      rdata = '0;
        endcase
    end

    assign irq = flag_q & ctrl_q[c_ctrl_im_bit];

endmodule : timer_counter
`default_nettype wire

// File: tb/tb_timer_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_counter
//  Description : Self-checking bench for timer_counter. Expected COUNT,
//                interrupt flag and CTRL.EN are derived from elapsed edges
//                since the enabling write, using the timer's period formula.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // k = edges after the enabling write; LOAD happens at k=1.
    // One full period is L = (N+1)*(P+1) + 2 edges (LOAD, counting, INT).
    function automatic int period(input int n, input int p);
        return (n + 1) * (p + 1) + 2;
    endfunction

    function automatic int exp_count(input int k, input int n, input int p,
                                     input bit ar, input int prev);
        int l, m;
        if (k <= 1) return prev;
        l = period(n, p);
        m = k - 1;
        if (ar) m = m % l;
        if (m == 0) return 0;                       // reload cycle after INT
        if (m <= l - 2) return n - (m - 1) / (p + 1);
        return 0;
    endfunction

    function automatic bit exp_flag(input int k, input int n, input int p, input bit ar);
        int l, m;
        if (k <= 1) return 1'b0;
        l = period(n, p);
        m = k - 1;
        if (ar) return (m % l) == l - 1;
        return m >= l - 1;
    endfunction

    function automatic int exp_en(input int k, input int n, input int p, input bit ar);
        if (ar) return 1;
        return (k - 1 < period(n, p)) ? 1 : 0;
    endfunction

    // ---------------- bus helpers ----------------
    task automatic wr(input logic [1:0] sel, input logic [31:0] d);
        @(negedge clk);
        addr  = {28'd0, sel, 2'b00};
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] sel, output logic [31:0] v);
        addr = {28'd0, sel, 2'b00};
        #1;
        v = rdata;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1;
        we = 1'b0; addr = '0; wdata = '0;
        #2;
        reset = 1'b0;
        #1;
        for (int r = 0; r < 4; r++) begin
            rd(r[1:0], v);
            n_checks++; if (v !== 32'd0) $display("FAIL reset_read[%0d]: got %0h want 0", r, v); else n_pass++;
        end
        n_checks++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset_mid_count();
        logic [31:0] c, v;
        bit found = 0;
        do_reset();
        wr(2'd1, 32'd100);
        wr(2'd0, 32'h9);
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            rd(2'd2, c);
            if (c == 32'd40) found = 1;
        end
        n_checks++; if (!found) $display("FAIL midreset_reach40: got %0d want 40", c); else n_pass++;
        #1;
        reset = 1'b0;
        rd(2'd2, v);
        n_checks++; if (v !== 32'd0) $display("FAIL midreset_count: got %0d want 0", v); else n_pass++;
        n_checks++; if (irq !== 1'b0) $display("FAIL midreset_irq: got %b want 0", irq); else n_pass++;
        rd(2'd0, v);
        n_checks++; if (v !== 32'd0) $display("FAIL midreset_ctrl: got %0h want 0", v); else n_pass++;
        rd(2'd1, v);
        n_checks++; if (v !== 32'd0) $display("FAIL midreset_preset: got %0d want 0", v); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) step();
        rd(2'd2, v);
        n_checks++; if (v !== 32'd0) $display("FAIL midreset_idle_count: got %0d want 0", v); else n_pass++;
    endtask

    task automatic test_oneshot();
        logic [31:0] c, ct;
        do_reset();
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 14; k++) begin
            step();
            rd(2'd2, c);
            rd(2'd0, ct);
            n_checks++; if (c !== 32'(exp_count(k, 5, 0, 0, 0))) $display("FAIL oneshot_count k=%0d: got %0d want %0d", k, c, exp_count(k, 5, 0, 0, 0)); else n_pass++;
            n_checks++; if (irq !== (k >= 8)) $display("FAIL oneshot_irq k=%0d: got %b want %b", k, irq, (k >= 8)); else n_pass++;
            n_checks++; if (ct !== ((k >= 9) ? 32'h8 : 32'h9)) $display("FAIL oneshot_ctrl k=%0d: got %0h", k, ct); else n_pass++;
        end
        wr(2'd0, 32'h0);
        n_checks++; if (irq !== 1'b0) $display("FAIL oneshot_clear_irq: got %b want 0", irq); else n_pass++;
    endtask

    task automatic test_autoreload();
        logic [31:0] c, ct;
        do_reset();
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 20; k++) begin
            step();
            rd(2'd2, c);
            rd(2'd0, ct);
            n_checks++; if (c !== 32'(exp_count(k, 3, 0, 1, 0))) $display("FAIL reload_count k=%0d: got %0d want %0d", k, c, exp_count(k, 3, 0, 1, 0)); else n_pass++;
            n_checks++; if (irq !== ((k % 6) == 0)) $display("FAIL reload_irq k=%0d: got %b want %b", k, irq, ((k % 6) == 0)); else n_pass++;
            n_checks++; if (ct !== 32'hB) $display("FAIL reload_ctrl k=%0d: got %0h want b", k, ct); else n_pass++;
        end
    endtask

    task automatic test_mask();
        logic [31:0] c, ct;
        do_reset();
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        for (int k = 1; k <= 10; k++) begin
            step();
            rd(2'd2, c);
            rd(2'd0, ct);
            n_checks++; if (c !== 32'(exp_count(k, 2, 0, 0, 0))) $display("FAIL mask_count k=%0d: got %0d want %0d", k, c, exp_count(k, 2, 0, 0, 0)); else n_pass++;
            n_checks++; if (irq !== 1'b0) $display("FAIL mask_irq k=%0d: got %b want 0", k, irq); else n_pass++;
            n_checks++; if (ct !== 32'(exp_en(k, 2, 0, 0))) $display("FAIL mask_ctrl k=%0d: got %0h want %0h", k, ct, exp_en(k, 2, 0, 0)); else n_pass++;
        end
        wr(2'd0, 32'h8);
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++; if (irq !== 1'b0) $display("FAIL mask_im_irq k=%0d: got %b want 0", k, irq); else n_pass++;
        end
        rd(2'd0, ct);
        n_checks++; if (ct !== 32'h8) $display("FAIL mask_im_ctrl: got %0h want 8", ct); else n_pass++;
    endtask

    task automatic test_pause_ignores();
        logic [31:0] c, v, exp3;
        bit found = 0;
        do_reset();
        wr(2'd1, 32'd20);
        wr(2'd0, 32'h1);
        for (int i = 0; i < 50 && !found; i++) begin
            step();
            rd(2'd2, c);
            if (c == 32'd8) found = 1;
        end
        n_checks++; if (!found) $display("FAIL pause_reach8: got %0d want 8", c); else n_pass++;
        wr(2'd0, 32'h0);          // this edge still decrements 8 -> 7
        for (int k = 0; k < 10; k++) begin
            rd(2'd2, c);
            n_checks++; if (c !== 32'd7) $display("FAIL pause_frozen k=%0d: got %0d want 7", k, c); else n_pass++;
            step();
        end
        wr(2'd2, 32'd123);
        rd(2'd2, c);
        n_checks++; if (c !== 32'd7) $display("FAIL count_write_ignored: got %0d want 7", c); else n_pass++;
        wr(2'd3, 32'hFFFF_FFFF);
`ifdef TC_PRESCALE_EN
        exp3 = 32'h0000_00FF;
`else
        exp3 = 32'h0;
`endif
        rd(2'd3, v);
        n_checks++; if (v !== exp3) $display("FAIL offset3_read: got %0h want %0h", v, exp3); else n_pass++;
        rd(2'd2, c);
        n_checks++; if (c !== 32'd7) $display("FAIL offset3_write_count: got %0d want 7", c); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] c, ct;
        int n, mode, im, p, l, ectl;
        bit ar;
        for (int it = 0; it < 8; it++) begin
            do_reset();
            n    = int'($urandom_range(0, 6));
            mode = int'($urandom_range(0, 3));
            im   = int'($urandom_range(0, 1));
            p    = 0;
`ifdef TC_PRESCALE_EN
            p = int'($urandom_range(0, 2));
            wr(2'd3, 32'(p));
`endif
            ar = (mode == 1);
            l  = period(n, p);
            wr(2'd1, 32'(n));
            wr(2'd0, 32'(im * 8 + mode * 2 + 1));
            for (int k = 1; k <= 2 * l + 2; k++) begin
                step();
                rd(2'd2, c);
                rd(2'd0, ct);
                ectl = im * 8 + mode * 2 + exp_en(k, n, p, ar);
                n_checks++; if (c !== 32'(exp_count(k, n, p, ar, 0))) $display("FAIL rand_count it=%0d k=%0d: got %0d want %0d", it, k, c, exp_count(k, n, p, ar, 0)); else n_pass++;
                n_checks++; if (irq !== (exp_flag(k, n, p, ar) && im == 1)) $display("FAIL rand_irq it=%0d k=%0d: got %b", it, k, irq); else n_pass++;
                n_checks++; if (ct !== 32'(ectl)) $display("FAIL rand_ctrl it=%0d k=%0d: got %0h want %0h", it, k, ct, ectl); else n_pass++;
            end
        end
    endtask

`ifdef TC_PRESCALE_EN
    task automatic test_prescale();
        logic [31:0] c;
        do_reset();
        wr(2'd3, 32'd2);
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 12; k++) begin
            step();
            rd(2'd2, c);
            n_checks++; if (c !== 32'(exp_count(k, 2, 2, 0, 0))) $display("FAIL presc_count k=%0d: got %0d want %0d", k, c, exp_count(k, 2, 2, 0, 0)); else n_pass++;
            n_checks++; if (irq !== (k >= 11)) $display("FAIL presc_irq k=%0d: got %b want %b", k, irq, (k >= 11)); else n_pass++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid_count();
        test_oneshot();
        test_autoreload();
        test_mask();
        test_pause_ignores();
`ifdef TC_PRESCALE_EN
        test_prescale();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_timer_counter
`default_nettype wire
